// File: rtl/color_scale.sv
// Per-channel RGB scaler: each 8-bit channel becomes floor(ch / DENOM), registered once.
// Power-of-two divisors are plain shifts; the others use a reciprocal multiply that is exact for 0..255.
module color_scale #(
  parameter logic [2:0] DENOM = 3'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic       out_valid,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out
);

  localparam bit IS_POW2 = (DENOM == 3'd1) || (DENOM == 3'd2) || (DENOM == 3'd4);

  // (x * MULT) >> SHIFT == floor(x / DENOM) for every 8-bit x; the error term stays below 1/DENOM.
  localparam int SHIFT = (DENOM == 3'd1) ? 0  :
                         (DENOM == 3'd2) ? 1  :
                         (DENOM == 3'd4) ? 2  :
                         (DENOM == 3'd3) ? 9  :
                         (DENOM == 3'd5) ? 10 :
                         (DENOM == 3'd6) ? 10 : 11;

  localparam logic [8:0] MULT = (DENOM == 3'd3) ? 9'd171 :
                                (DENOM == 3'd5) ? 9'd205 :
                                (DENOM == 3'd6) ? 9'd171 :
                                (DENOM == 3'd7) ? 9'd293 : 9'd1;

  generate
    if (DENOM == 3'd0) begin : g_bad_denom
      $error("color_scale: DENOM must be in 1..7");
    end
  endgenerate

  function automatic logic [7:0] scale(input logic [7:0] x);
    logic [16:0] prod;
    prod = x * MULT;
    if (IS_POW2) return x >> SHIFT;
    return 8'(prod >> SHIFT);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      r_out     <= 8'h00;
      g_out     <= 8'h00;
      b_out     <= 8'h00;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        r_out <= scale(r_in);
        g_out <= scale(g_in);
        b_out <= scale(b_in);
      end
    end
  end

endmodule

// File: tb/tb_color_scale.sv
// Directed bench for color_scale: one instance per DENOM 1..7 sharing the same stimulus.
module tb_color_scale;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] r_in, g_in, b_in;

  logic       v_o [1:7];
  logic [7:0] r_o [1:7];
  logic [7:0] g_o [1:7];
  logic [7:0] b_o [1:7];

  int n_cmp;
  int n_err;

  for (genvar d = 1; d <= 7; d++) begin : g_dut
    color_scale #(.DENOM(3'(d))) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .r_in     (r_in),
      .g_in     (g_in),
      .b_in     (b_in),
      .out_valid(v_o[d]),
      .r_out    (r_o[d]),
      .g_out    (g_o[d]),
      .b_out    (b_o[d])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int d, input logic v, input logic [23:0] rgb);
    logic [24:0] obs;
    logic [24:0] exp;
    obs = {v_o[d], r_o[d], g_o[d], b_o[d]};
    exp = {v, rgb};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s D=%0d got v=%b rgb=%h expected v=%b rgb=%h",
             tag, d, obs[24], obs[23:0], exp[24], exp[23:0]);
    end
  endtask

  task automatic drive(input logic v, input logic [23:0] rgb);
    in_valid = v;
    {r_in, g_in, b_in} = rgb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] gx, bx;
    n_cmp = 0;
    n_err = 0;

    // reset with valid FFFFFF held
    rst_n = 1'b0;
    drive(1'b1, 24'hFFFFFF);
    tick();
    chk("reset_edge1", 2, 1'b0, 24'h000000);
    chk("reset_edge1", 4, 1'b0, 24'h000000);
    tick();
    chk("reset_edge2", 2, 1'b0, 24'h000000);
    chk("reset_edge2", 7, 1'b0, 24'h000000);

    // primaries and black
    rst_n = 1'b1;
    drive(1'b1, 24'h000000);
    tick();
    chk("black", 2, 1'b1, 24'h000000);
    chk("black", 4, 1'b1, 24'h000000);
    drive(1'b1, 24'hFF0000);
    tick();
    chk("red", 2, 1'b1, 24'h7F0000);
    chk("red", 4, 1'b1, 24'h3F0000);
    drive(1'b1, 24'h00FF00);
    tick();
    chk("green", 2, 1'b1, 24'h007F00);
    chk("green", 4, 1'b1, 24'h003F00);
    drive(1'b1, 24'h0000FF);
    tick();
    chk("blue", 2, 1'b1, 24'h00007F);
    chk("blue", 4, 1'b1, 24'h00003F);

    // mixed and white
    drive(1'b1, 24'h007F7F);
    tick();
    chk("mixed", 2, 1'b1, 24'h003F3F);
    chk("mixed", 4, 1'b1, 24'h001F1F);
    drive(1'b1, 24'hFFFFFF);
    tick();
    chk("white", 1, 1'b1, 24'hFFFFFF);
    chk("white", 2, 1'b1, 24'h7F7F7F);
    chk("white", 4, 1'b1, 24'h3F3F3F);

    // spot values for non-power-of-two divisors
    drive(1'b1, 24'hFFFF04);
    tick();
    chk("spot", 3, 1'b1, 24'h555501);
    chk("spot", 5, 1'b1, 24'h333300);
    chk("spot", 6, 1'b1, 24'h2A2A00);
    chk("spot", 7, 1'b1, 24'h242400);

    // exhaustive sweep, each channel gets a different pattern
    for (int i = 0; i < 256; i++) begin
      x  = 8'(i);
      gx = x ^ 8'h5A;
      bx = 8'hFF - x;
      drive(1'b1, {x, gx, bx});
      tick();
      for (int d = 1; d <= 7; d++) begin
        chk("sweep", d, 1'b1,
            {8'(int'(x) / d), 8'(int'(gx) / d), 8'(int'(bx) / d)});
      end
    end

    // back-to-back then a one-cycle bubble
    drive(1'b1, 24'h102030);
    tick();
    chk("b2b_a", 2, 1'b1, 24'h081018);
    chk("b2b_a", 4, 1'b1, 24'h04080C);
    drive(1'b1, 24'h405060);
    tick();
    chk("b2b_b", 2, 1'b1, 24'h202830);
    chk("b2b_b", 4, 1'b1, 24'h101418);
    drive(1'b1, 24'h90A0B0);
    tick();
    chk("b2b_c", 2, 1'b1, 24'h485058);
    chk("b2b_c", 4, 1'b1, 24'h24282C);
    drive(1'b0, 24'hFFFFFF);
    tick();
    chk("bubble_hold", 2, 1'b0, 24'h485058);
    chk("bubble_hold", 4, 1'b0, 24'h24282C);
    drive(1'b1, 24'h0000FF);
    tick();
    chk("after_bubble", 2, 1'b1, 24'h00007F);

    // mid-stream reset
    drive(1'b1, 24'h102030);
    tick();
    chk("stream_pre", 2, 1'b1, 24'h081018);
    rst_n = 1'b0;
    drive(1'b1, 24'h405060);
    tick();
    chk("mid_reset", 2, 1'b0, 24'h000000);
    chk("mid_reset", 4, 1'b0, 24'h000000);
    rst_n = 1'b1;
    drive(1'b1, 24'h90A0B0);
    tick();
    chk("resume", 2, 1'b1, 24'h485058);
    chk("resume", 4, 1'b1, 24'h24282C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
